// File: rtl/mips_cpu_alu_regfile.sv
// Execute datapath of the multicycle MIPS-I CPU: 32x32 register file plus combinational ALU.
// Optional write-to-read bypass when MIPS_REGFILE_BYPASS_EN is defined.
module mips_cpu_alu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  funct,
  input  logic [5:0]  opcode,
  input  logic [4:0]  shamt,
  input  logic [15:0] immediate,
  input  logic [4:0]  read_index_rs,
  input  logic [4:0]  read_index_rt,
  output logic [31:0] read_data_rs,
  output logic [31:0] read_data_rt,
  input  logic [4:0]  write_index,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] register_v0,
  input  logic        carry_in,
  output logic [31:0] alu_out,
  output logic        branch,
  output logic        carry_out,
  output logic        zero
);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  logic [31:0][31:0] regs;

  // Index 0 is never written, so it stays zero from reset onward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      regs <= '0;
    else if (write_enable && write_index != 5'd0)
      regs[write_index] <= write_data;
  end

`ifdef MIPS_REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = write_enable && reset && (write_index != 5'd0);
`endif

  always_comb begin
    read_data_rs = (read_index_rs == 5'd0) ? 32'd0 : regs[read_index_rs];
    read_data_rt = (read_index_rt == 5'd0) ? 32'd0 : regs[read_index_rt];
    register_v0  = regs[2];
`ifdef MIPS_REGFILE_BYPASS_EN
    if (byp_ok && write_index == read_index_rs) read_data_rs = write_data;
    if (byp_ok && write_index == read_index_rt) read_data_rt = write_data;
    if (byp_ok && write_index == 5'd2)          register_v0  = write_data;
`endif
  end

  logic [31:0] a, b, sext, zext;
  logic [32:0] add_ab, sub_ab, add_imm;

  assign a       = read_data_rs;
  assign b       = read_data_rt;
  assign sext    = {{16{immediate[15]}}, immediate};
  assign zext    = {16'h0, immediate};
  assign add_ab  = {1'b0, a} + {1'b0, b};
  // Subtract as A + ~B + 1 so carry_out follows the MIPS borrow-inverted convention.
  assign sub_ab  = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign add_imm = {1'b0, a} + {1'b0, sext};

  always_comb begin
    alu_out   = 32'd0;
    branch    = 1'b0;
    carry_out = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'b000000: alu_out = b << shamt;
          6'b000010: alu_out = b >> shamt;
          6'b000011: alu_out = $signed(b) >>> shamt;
          6'b000100: alu_out = b << a[4:0];
          6'b000110: alu_out = b >> a[4:0];
          6'b000111: alu_out = $signed(b) >>> a[4:0];
          6'b100001: begin alu_out = add_ab[31:0]; carry_out = add_ab[32]; end
          6'b100011: begin alu_out = sub_ab[31:0]; carry_out = sub_ab[32]; end
          6'b100100: alu_out = a & b;
          6'b100101: alu_out = a | b;
          6'b100110: alu_out = a ^ b;
          6'b100111: alu_out = ~(a | b);
          6'b101010: alu_out = {31'd0, $signed(a) < $signed(b)};
          6'b101011: alu_out = {31'd0, a < b};
          default:   alu_out = 32'd0;
        endcase
      end
      OP_ADDIU,
      6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
      6'b101000, 6'b101001, 6'b101011: begin
        alu_out   = add_imm[31:0];
        carry_out = add_imm[32];
      end
      OP_SLTI:  alu_out = {31'd0, $signed(a) < $signed(sext)};
      OP_SLTIU: alu_out = {31'd0, a < sext};
      OP_ANDI:  alu_out = a & zext;
      OP_ORI:   alu_out = a | zext;
      OP_XORI:  alu_out = a ^ zext;
      OP_LUI:   alu_out = {immediate, 16'h0};
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        alu_out   = sub_ab[31:0];
        carry_out = sub_ab[32];
        case (opcode)
          OP_BEQ:  branch = (a == b);
          OP_BNE:  branch = (a != b);
          OP_BLEZ: branch = a[31] | (a == 32'd0);
          OP_BGTZ: branch = ~a[31] & (a != 32'd0);
          default: begin
            case (read_index_rt)
              5'b00000, 5'b10000: branch = a[31];
              5'b00001, 5'b10001: branch = ~a[31];
              default:            branch = 1'b0;
            endcase
          end
        endcase
      end
      default: alu_out = 32'd0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

  // carry_in is reserved by the control FSM interface and intentionally has no effect.
  logic unused_ok;
  assign unused_ok = &{1'b0, carry_in};

endmodule

// File: tb/tb_mips_cpu_alu_regfile.sv
// Scoreboard bench for mips_cpu_alu_regfile: expectations queued at drive time, compared after settle.
module tb_mips_cpu_alu_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  funct, opcode;
  logic [4:0]  shamt, read_index_rs, read_index_rt, write_index;
  logic [15:0] immediate;
  logic [31:0] read_data_rs, read_data_rt, write_data, register_v0, alu_out;
  logic        write_enable, carry_in, branch, carry_out, zero;

  mips_cpu_alu_regfile dut (
    .clk(clk), .reset(reset), .funct(funct), .opcode(opcode), .shamt(shamt),
    .immediate(immediate), .read_index_rs(read_index_rs), .read_index_rt(read_index_rt),
    .read_data_rs(read_data_rs), .read_data_rt(read_data_rt), .write_index(write_index),
    .write_enable(write_enable), .write_data(write_data), .register_v0(register_v0),
    .carry_in(carry_in), .alu_out(alu_out), .branch(branch), .carry_out(carry_out),
    .zero(zero)
  );

  always #5 clk = ~clk;

  localparam int S_ALU = 0, S_BR = 1, S_CY = 2, S_ZR = 3, S_RS = 4, S_RT = 5, S_V0 = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain;
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        S_ALU:   obs = alu_out;
        S_BR:    obs = {31'd0, branch};
        S_CY:    obs = {31'd0, carry_out};
        S_ZR:    obs = {31'd0, zero};
        S_RS:    obs = read_data_rs;
        S_RT:    obs = read_data_rt;
        default: obs = register_v0;
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                    input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt);
    opcode = opc; funct = fn; shamt = sh; immediate = imm;
    read_index_rs = rs; read_index_rt = rt;
  endtask

  task automatic expect_alu(input string tag, input logic [31:0] res, input logic br,
                            input logic cy);
    push({tag, ".alu"}, S_ALU, res);
    push({tag, ".br"},  S_BR,  {31'd0, br});
    push({tag, ".cy"},  S_CY,  {31'd0, cy});
    push({tag, ".z"},   S_ZR,  {31'd0, res == 32'd0});
    drain();
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    write_index = idx; write_data = data; write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b0; write_enable = 1'b0; write_index = '0; write_data = '0; carry_in = 1'b0;
    op(6'd0, 6'd0, 5'd0, 16'd0, 5'd2, 5'd31);
    #12;
    push("rst_rs", S_RS, 32'd0);
    push("rst_rt", S_RT, 32'd0);
    push("rst_v0", S_V0, 32'd0);
    drain();
    @(negedge clk);
    reset = 1'b1;

    wr(5'd2, 32'h12345678);
    push("v0_write", S_V0, 32'h12345678);
    drain();
    wr(5'd0, 32'hFFFFFFFF);
    op(6'd0, 6'd0, 5'd0, 16'd0, 5'd0, 5'd2);
    push("r0_read", S_RS, 32'd0);
    push("r2_read", S_RT, 32'h12345678);
    drain();

    wr(5'd1, 32'hFFFFFFFF);
    wr(5'd3, 32'd1);
    wr(5'd4, 32'h80000000);
    wr(5'd5, 32'd10);
    wr(5'd6, 32'd5);
    wr(5'd8, 32'd5);
    @(negedge clk);
    carry_in = 1'b1;

    op(6'b000000, 6'b100001, 5'd0, 16'd0, 5'd1, 5'd3);  expect_alu("addu_wrap", 32'd0, 1'b0, 1'b1);
    op(6'b000000, 6'b100011, 5'd0, 16'd0, 5'd6, 5'd3);  expect_alu("subu", 32'd4, 1'b0, 1'b1);
    op(6'b000000, 6'b100011, 5'd0, 16'd0, 5'd3, 5'd1);  expect_alu("subu_neg", 32'd2, 1'b0, 1'b0);
    op(6'b000000, 6'b000011, 5'd4, 16'd0, 5'd0, 5'd4);  expect_alu("sra", 32'hF8000000, 1'b0, 1'b0);
    op(6'b000000, 6'b000010, 5'd4, 16'd0, 5'd0, 5'd4);  expect_alu("srl", 32'h08000000, 1'b0, 1'b0);
    op(6'b000000, 6'b000000, 5'd31, 16'd0, 5'd0, 5'd3); expect_alu("sll", 32'h80000000, 1'b0, 1'b0);
    op(6'b000000, 6'b000100, 5'd0, 16'd0, 5'd6, 5'd3);  expect_alu("sllv", 32'h20, 1'b0, 1'b0);
    op(6'b000000, 6'b000111, 5'd0, 16'd0, 5'd6, 5'd4);  expect_alu("srav", 32'hFC000000, 1'b0, 1'b0);
    op(6'b000000, 6'b100111, 5'd0, 16'd0, 5'd0, 5'd0);  expect_alu("nor", 32'hFFFFFFFF, 1'b0, 1'b0);
    op(6'b000000, 6'b101010, 5'd0, 16'd0, 5'd1, 5'd3);  expect_alu("slt", 32'd1, 1'b0, 1'b0);
    op(6'b000000, 6'b101011, 5'd0, 16'd0, 5'd1, 5'd3);  expect_alu("sltu", 32'd0, 1'b0, 1'b0);
    op(6'b000000, 6'b011000, 5'd0, 16'd0, 5'd1, 5'd3);  expect_alu("mult_nop", 32'd0, 1'b0, 1'b0);
    op(6'b001111, 6'd0, 5'd0, 16'hABCD, 5'd1, 5'd0);    expect_alu("lui", 32'hABCD0000, 1'b0, 1'b0);
    op(6'b001001, 6'd0, 5'd0, 16'hFFFF, 5'd5, 5'd0);    expect_alu("addiu", 32'd9, 1'b0, 1'b1);
    op(6'b001010, 6'd0, 5'd0, 16'hFFFF, 5'd5, 5'd0);    expect_alu("slti", 32'd0, 1'b0, 1'b0);
    op(6'b001011, 6'd0, 5'd0, 16'hFFFF, 5'd5, 5'd0);    expect_alu("sltiu", 32'd1, 1'b0, 1'b0);
    op(6'b001100, 6'd0, 5'd0, 16'h8001, 5'd1, 5'd0);    expect_alu("andi", 32'h00008001, 1'b0, 1'b0);
    op(6'b001101, 6'd0, 5'd0, 16'hF000, 5'd3, 5'd0);    expect_alu("ori", 32'h0000F001, 1'b0, 1'b0);
    op(6'b001110, 6'd0, 5'd0, 16'hFFFF, 5'd1, 5'd0);    expect_alu("xori", 32'hFFFF0000, 1'b0, 1'b0);
    op(6'b100011, 6'd0, 5'd0, 16'h0004, 5'd5, 5'd1);    expect_alu("lw_addr", 32'd14, 1'b0, 1'b0);
    op(6'b101011, 6'd0, 5'd0, 16'hFFFE, 5'd5, 5'd1);    expect_alu("sw_addr", 32'd8, 1'b0, 1'b1);
    op(6'b000001, 6'd0, 5'd0, 16'd0, 5'd0, 5'd1);       expect_alu("bgez", 32'd1, 1'b1, 1'b0);
    op(6'b000001, 6'd0, 5'd0, 16'd0, 5'd1, 5'd0);       expect_alu("bltz", 32'hFFFFFFFF, 1'b1, 1'b1);
    op(6'b000001, 6'd0, 5'd0, 16'd0, 5'd1, 5'd2);       expect_alu("regimm_bad", 32'hEDCBA987, 1'b0, 1'b1);
    op(6'b000101, 6'd0, 5'd0, 16'd0, 5'd6, 5'd8);       expect_alu("bne", 32'd0, 1'b0, 1'b1);
    op(6'b000100, 6'd0, 5'd0, 16'd0, 5'd6, 5'd8);       expect_alu("beq", 32'd0, 1'b1, 1'b1);
    op(6'b000110, 6'd0, 5'd0, 16'd0, 5'd0, 5'd0);       expect_alu("blez0", 32'd0, 1'b1, 1'b1);
    op(6'b000111, 6'd0, 5'd0, 16'd0, 5'd5, 5'd0);       expect_alu("bgtz", 32'd10, 1'b1, 1'b1);
    op(6'b000111, 6'd0, 5'd0, 16'd0, 5'd1, 5'd0);       expect_alu("bgtz_neg", 32'hFFFFFFFF, 1'b0, 1'b1);
    op(6'b000010, 6'd0, 5'd0, 16'h1234, 5'd1, 5'd3);    expect_alu("j_nop", 32'd0, 1'b0, 1'b0);

    // Same-cycle read of the register being written.
    @(negedge clk);
    op(6'd0, 6'd0, 5'd0, 16'd0, 5'd3, 5'd0);
    write_index = 5'd3; write_data = 32'h00000077; write_enable = 1'b1;
`ifdef MIPS_REGFILE_BYPASS_EN
    push("same_cycle_rd", S_RS, 32'h00000077);
`else
    push("same_cycle_rd", S_RS, 32'd1);
`endif
    drain();
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    push("after_write_rd", S_RS, 32'h00000077);
    drain();

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    reset = 1'b0;
    op(6'b000000, 6'b100001, 5'd0, 16'd0, 5'd1, 5'd5);
    push("midrst_rs", S_RS, 32'd0);
    push("midrst_rt", S_RT, 32'd0);
    push("midrst_v0", S_V0, 32'd0);
    push("midrst_alu", S_ALU, 32'd0);
    drain();
    write_index = 5'd2; write_data = 32'hDEADBEEF; write_enable = 1'b1;
    @(posedge clk);
    #1;
    push("wr_in_reset", S_V0, 32'd0);
    drain();
    @(negedge clk);
    reset = 1'b1; write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    push("first_wr", S_V0, 32'hCAFEF00D);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_alu_regfile.md
# mips_cpu_alu_regfile

Combinational ALU plus 32×32-bit register file forming the execute datapath of the multicycle MIPS-I CPU.
- The control FSM supplies decoded instruction fields and register indices, and receives ALU result, branch decision and status flags.
- Register reads are asynchronous; register writes are committed on the clock edge.
- `$v0` is exported for the top-level `register_v0` port.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all register writes on rising edge.
- `reset` in 1: asynchronous, active-low; clears all registers.
- `funct` in 6: instr[5:0], R-type operation select.
- `opcode` in 6: instr[31:26].
- `shamt` in 5: instr[10:6].
- `immediate` in 16: instr[15:0].
- `read_index_rs` in 5: rs index; ALU operand A source.
- `read_index_rt` in 5: rt index; ALU operand B source; also the REGIMM condition field.
- `read_data_rs` out 32: GPR[rs].
- `read_data_rt` out 32: GPR[rt].
- `write_index` in 5: destination register.
- `write_enable` in 1: commit `write_data` at the next edge.
- `write_data` in 32: write-back value.
- `register_v0` out 32: GPR[2], continuous.
- `carry_in` in 1: previous carry status; reserved, no effect on any output.
- `alu_out` out 32: ALU result.
- `branch` out 1: branch condition true.
- `carry_out` out 1: carry of the current add/sub.
- `zero` out 1: `alu_out == 0`.

## Operation
Register file:
- 32 registers, each 32 bits.
- GPR[0] always reads 0; writes to it are discarded.
- Read ports are combinational.

Immediate extension:
- `sext` = sign-extend `immediate`.
- `zext` = zero-extend `immediate`.

ALU, with A = `read_data_rs` and B = `read_data_rt`.

R-type (`opcode` 000000), selected by `funct`:
- SLL 000000: B<<shamt
- SRL 000010: B>>shamt, logical
- SRA 000011: B>>>shamt, arithmetic
- SLLV 000100: B<<A[4:0]
- SRLV 000110: B>>A[4:0], logical
- SRAV 000111: B>>>A[4:0], arithmetic
- ADDU 100001: A+B
- SUBU 100011: A−B
- AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise
- SLT 101010: signed A<B → 1 else 0
- SLTU 101011: unsigned A<B → 1 else 0
- Any other `funct` (JR, JALR, MFHI, MULT, …): `alu_out` = 0.

Immediate opcodes:
- ADDIU 001001: A+sext
- SLTI 001010: signed A<sext
- SLTIU 001011: unsigned A<sext
- ANDI 001100, ORI 001101, XORI 001110: operate with zext
- LUI 001111: {immediate, 16'h0}

Loads and stores (100000–100110, 101000, 101001, 101011):
- `alu_out` = A+sext (effective byte address).

Branches:
- `alu_out` = A−B for all branch opcodes.
- BEQ 000100: `branch` = A==B.
- BNE 000101: `branch` = A!=B.
- BLEZ 000110: `branch` = signed A<=0.
- BGTZ 000111: `branch` = signed A>0.
- REGIMM 000001, condition from `read_index_rt`:
  - 00000 BLTZ and 10000 BLTZAL: `branch` = A<0.
  - 00001 BGEZ and 10001 BGEZAL: `branch` = A>=0.
  - Any other rt value: `branch` = 0.

Flags:
- `branch` = 0 for every non-branch opcode.
- All other opcodes (J, JAL, unimplemented): `alu_out` = 0.
- `carry_out` = bit 32 of the 33-bit add for ADDU, ADDIU and load/store address.
- For SUBU and branch subtract, `carry_out` = bit 32 of A + ~B + 1.
- `carry_out` = 0 for all other operations.

## Timing
- ALU is purely combinational; outputs settle within the same cycle as their inputs.
- Register write: GPR[`write_index`] ← `write_data` on the rising `clk` edge where `write_enable`=1 and `reset`=1.
- Register reads are combinational from current register contents.
- Read of the index being written in the same cycle returns the old value (unless bypass is enabled, see Configuration).
- `reset` low: all 32 registers cleared to 0 immediately, independent of `clk`.
  - `register_v0`, `read_data_*` and every ALU output derived from them therefore read 0.
  - Any write pending on that edge is lost.
- Write during reset is ignored.
- First write is possible on the first edge after `reset` deasserts.

## Configuration
- `MIPS_REGFILE_BYPASS_EN` defined:
  - When `write_enable`=1, `write_index`≠0 and `write_index` equals a read index, that read port returns `write_data` combinationally.
  - The same applies to `register_v0` when `write_index`=2.
- Not defined: no bypass; reads always reflect stored contents.

## Test plan
- Reset, then write GPR[2]=32'h12345678 → `register_v0` = 32'h12345678 after the edge.
- Write GPR[0]=32'hFFFFFFFF → `read_data_rs` for index 0 = 0.
- ADDU with rs=32'hFFFFFFFF, rt=1 → `alu_out` = 0, `zero`=1, `carry_out`=1.
- SRA with B=32'h80000000, shamt=4 → `alu_out` = 32'hF8000000.
- SLT with A=32'hFFFFFFFF, B=1 → `alu_out` = 1.
- SLTU with the same operands → `alu_out` = 0.
- LUI with imm=16'hABCD → `alu_out` = 32'hABCD0000.
- ADDIU with A=10, imm=16'hFFFF → `alu_out` = 9.
- BGEZ (opcode 000001, rt=1), A=0 → `branch`=1.
- BNE with A=B=5 → `branch`=0.
- Reset asserted mid-cycle after writes → all reads return 0 immediately.
